// File: rtl/fifo_wr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg: shared FSM state type and round-robin search helper | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int MAX_NREQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping to 0; only the low nreq bits count.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                       input logic [3:0]          ptr,
                                       input int                  nreq);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!r.found && req[j[3:0]]) begin
          r.found = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: combinational wrap-around priority search from ptr | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  logic [MAX_NREQ-1:0] w_req_ext;
  logic [3:0]          w_ptr_ext;
  rr_pick_t            w_pick;

  always_comb begin
    w_req_ext           = '0;
    w_req_ext[NREQ-1:0] = req;
    w_ptr_ext           = '0;
    w_ptr_ext[PW-1:0]   = ptr;
    w_pick              = rr_pick(w_req_ext, w_ptr_ext, NREQ);
    idx                 = PW'(w_pick.idx);
    any                 = w_pick.found;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter: round-robin, burst-locking arbiter for the FIFO write port | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                  w_clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  full,
  output logic                  wr_rq,
  output logic [WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  forced_release
);

  localparam int              PW       = $clog2(NREQ);
  localparam int              CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0]   TOP_IDX  = PW'(NREQ - 1);

  arb_state_t      r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic            r_forced, w_forced_nxt;
  logic [PW-1:0]   w_pick_idx;
  logic            w_pick_any;
  logic            w_xfer;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  // Reset forces IDLE asynchronously, which gates every write-side output to 0.
  assign w_xfer    = (r_state == BURST) & req_valid[r_owner] & ~full;
  assign wr_rq     = w_xfer;
  assign req_ready = w_xfer ? (NREQ'(1) << r_owner) : '0;
  assign wdata     = w_xfer ? req_data[r_owner*WIDTH +: WIDTH] : '0;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    w_grant_nxt    = r_grant;
    w_forced_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_nxt = '0;
        if (w_pick_any) begin
          w_owner_nxt    = w_pick_idx;
          w_grant_nxt    = NREQ'(1) << w_pick_idx;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = BURST;
        end
      end
      BURST: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          // The pointer moves only on release so every requester waits at most NREQ-1 bursts.
          if (req_last[r_owner] || (r_beat_cnt == LAST_CNT)) begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_rr_ptr_nxt = (r_owner == TOP_IDX) ? '0 : r_owner + PW'(1);
            w_forced_nxt = ~req_last[r_owner];
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
      r_forced   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_forced   <= w_forced_nxt;
    end
  end

  assign grant          = r_grant;
  assign forced_release = r_forced;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        full;
  logic        wr_rq;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        forced_release;

  int pass_n = 0;
  int total_n = 0;

  // Requester model: enable, burst length (0 = never last), beat budget (0 = unlimited), beats sent.
  int en[4];
  int len[4];
  int tot[4];
  int seq[4];

  fifo_wr_arbiter #(
    .WIDTH     (8),
    .NREQ      (4),
    .MAX_BURST (16)
  ) dut (
    .w_clk          (w_clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .full           (full),
    .wr_rq          (wr_rq),
    .wdata          (wdata),
    .grant          (grant),
    .forced_release (forced_release)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [7:0] dat(input int i, input int s);
    return 8'(((i & 7) << 5) | (s & 31));
  endfunction

  task automatic set_src(input int i, input int e, input int l, input int t);
    en[i]  = e;
    len[i] = l;
    tot[i] = t;
    seq[i] = 0;
  endtask

  task automatic drive();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      if (en[i] != 0 && (tot[i] == 0 || seq[i] < tot[i])) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = dat(i, seq[i]);
        req_last[i]         = (len[i] != 0) && ((seq[i] % len[i]) == len[i] - 1);
      end
    end
  endtask

  task automatic adv();
    logic [3:0] rdy;
    rdy = req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) if (rdy[i]) seq[i]++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) begin
      pass_n++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".wr_rq"}, 32'(wr_rq), 32'h0);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".wdata"}, 32'(wdata), 32'h0);
  endtask

  task automatic exp_beat(input string tag, input int o, input logic [7:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(1 << o));
    chk({tag, ".wr_rq"}, 32'(wr_rq), 32'h1);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(1 << o));
    chk({tag, ".wdata"}, 32'(wdata), 32'(d));
  endtask

  task automatic exp_stall(input string tag, input int o);
    chk({tag, ".grant"}, 32'(grant), 32'(1 << o));
    chk({tag, ".wr_rq"}, 32'(wr_rq), 32'h0);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".wdata"}, 32'(wdata), 32'h0);
  endtask

  initial begin
    int o;
    for (int i = 0; i < 4; i++) set_src(i, 0, 0, 0);
    rst_n = 1'b0;
    full  = 1'b0;
    drive();

    // Reset state, then an idle stretch with no requests.
    @(posedge w_clk);
    #2;
    exp_idle("reset");
    chk("reset.forced", 32'(forced_release), 32'h0);
    rst_n = 1'b1;
    @(posedge w_clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      drive(); #1;
      exp_idle("idle10");
      adv();
    end

    // Requesters 1 and 3 alternate 3-beat bursts, one IDLE cycle between grants.
    set_src(1, 1, 3, 0);
    set_src(3, 1, 3, 0);
    for (int b = 0; b < 4; b++) begin
      o = (b % 2 == 0) ? 1 : 3;
      drive(); #1;
      exp_idle("rr13.gap");
      adv();
      for (int k = 0; k < 3; k++) begin
        drive(); #1;
        exp_beat("rr13.beat", o, dat(o, 3 * (b / 2) + k));
        adv();
      end
    end
    set_src(1, 0, 0, 0);
    set_src(3, 0, 0, 0);

    // Owner 0 stalls on full for 5 cycles mid-burst and resumes without loss.
    set_src(0, 1, 6, 6);
    drive(); #1;
    exp_idle("full.gap");
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(); #1;
      exp_beat("full.pre", 0, dat(0, k));
      adv();
    end
    full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(); #1;
      exp_stall("full.hold", 0);
      adv();
    end
    full = 1'b0;
    for (int k = 2; k < 6; k++) begin
      drive(); #1;
      exp_beat("full.post", 0, dat(0, k));
      adv();
    end
    set_src(0, 0, 0, 0);

    // Requester 2 streams past the burst limit; 0 and 1 are served before it returns.
    set_src(2, 1, 20, 20);
    drive(); #1;
    exp_idle("force.gap");
    adv();
    set_src(0, 1, 1, 1);
    set_src(1, 1, 1, 1);
    for (int k = 0; k < 16; k++) begin
      drive(); #1;
      exp_beat("force.beat", 2, dat(2, k));
      chk("force.pulse_lo", 32'(forced_release), 32'h0);
      adv();
    end
    drive(); #1;
    exp_idle("force.rel");
    chk("force.pulse", 32'(forced_release), 32'h1);
    adv();
    drive(); #1;
    exp_beat("force.r0", 0, dat(0, 0));
    chk("force.pulse_once", 32'(forced_release), 32'h0);
    adv();
    drive(); #1;
    exp_idle("force.gap0");
    adv();
    drive(); #1;
    exp_beat("force.r1", 1, dat(1, 0));
    adv();
    drive(); #1;
    exp_idle("force.gap1");
    adv();
    for (int k = 16; k < 20; k++) begin
      drive(); #1;
      exp_beat("force.r2", 2, dat(2, k));
      adv();
    end
    drive(); #1;
    exp_idle("force.end");
    chk("force.last_no_pulse", 32'(forced_release), 32'h0);
    set_src(2, 0, 0, 0);

    // Move the pointer to 2 with one burst from requester 1, then all four single-beat.
    set_src(1, 1, 1, 1);
    adv();
    drive(); #1;
    exp_idle("all.pre_gap");
    adv();
    drive(); #1;
    exp_beat("all.pre", 1, dat(1, 0));
    adv();
    for (int i = 0; i < 4; i++) set_src(i, 1, 1, 2);
    for (int b = 0; b < 5; b++) begin
      o = (2 + b) % 4;
      drive(); #1;
      exp_idle("all.gap");
      adv();
      drive(); #1;
      exp_beat("all.beat", o, dat(o, (b == 4) ? 1 : 0));
      adv();
    end
    for (int i = 0; i < 4; i++) set_src(i, 0, 0, 0);

    // Reset during the 2nd beat of requester 3's burst; arbitration restarts at pointer 0.
    set_src(3, 1, 4, 4);
    drive(); #1;
    exp_idle("rst.gap");
    adv();
    drive(); #1;
    exp_beat("rst.beat0", 3, dat(3, 0));
    adv();
    drive(); #1;
    exp_beat("rst.beat1_pre", 3, dat(3, 1));
    rst_n = 1'b0;
    #1;
    exp_idle("rst.async");
    adv();
    set_src(1, 1, 1, 1);
    drive(); #1;
    rst_n = 1'b1;
    #1;
    exp_idle("rst.release");
    adv();
    drive(); #1;
    exp_beat("rst.first", 1, dat(1, 0));
    adv();
    drive(); #1;
    exp_idle("rst.gap2");
    adv();
    drive(); #1;
    exp_beat("rst.rearb", 3, dat(3, 1));
    adv();
    for (int i = 0; i < 4; i++) set_src(i, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

`default_nettype wire
